// File: rtl/rv_pkg.sv
// Shared definitions for the fetch front end: NOP encoding, default reset PC,
// fetch FSM state encoding and a word-alignment helper.
package rv_pkg;

  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0100_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, word} entries with flush; head is visible the cycle
// after the push (no bypass). DEPTH must be a power of two.
module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [63:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign pop_ok  = pop && !empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clock) begin
    if (push_ok && !flush) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order word requests, response buffering and
// redirect flush. Define FETCH_PERF_EN to add perf_fetched/perf_dropped counters.
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RV_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH);

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  rsp_pc_reg, rsp_pc_next;
  logic [CW:0]  outstanding_reg, outstanding_next;
  logic [CW:0]  drop_cnt_reg, drop_cnt_next;

  logic [63:0]  fifo_head;
  logic [CW:0]  fifo_count;
  logic         fifo_empty;
  logic         fifo_full;
  logic [CW+1:0] occupancy;
  logic         req_fire;
  logic         rsp_drop;
  logic         push;
  logic         pop;

  // Outstanding requests reserve FIFO space, so a response never overflows.
  assign occupancy      = {1'b0, outstanding_reg} + {1'b0, fifo_count};
  assign imem_req_valid = (state_reg != ST_IDLE) && !redirect_valid && !fifo_full
                          && (occupancy < (CW+2)'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (redirect_valid || (drop_cnt_reg != '0));
  assign push     = imem_rsp_valid && !rsp_drop;

  assign inst_valid = !fifo_empty && !redirect_valid;
  assign inst       = fifo_empty ? RV_NOP : fifo_head[31:0];
  assign inst_pc    = fifo_empty ? rsp_pc_reg : fifo_head[63:32];
  assign pop        = inst_valid && inst_ready;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({rsp_pc_reg, imem_rsp_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    drop_cnt_next    = drop_cnt_reg;
    outstanding_next = outstanding_reg + (CW+1)'(req_fire) - (CW+1)'(imem_rsp_valid);

    if (redirect_valid) begin
      // Everything accepted before this cycle is stale, including this cycle's response.
      fetch_pc_next = word_align(redirect_pc);
      rsp_pc_next   = word_align(redirect_pc);
      drop_cnt_next = outstanding_reg - (CW+1)'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (imem_rsp_valid) begin
        if (drop_cnt_reg != '0) drop_cnt_next = drop_cnt_reg - (CW+1)'(1);
        else                    rsp_pc_next   = rsp_pc_reg + 32'd4;
      end
    end

    case (state_reg)
      ST_IDLE: state_next = ST_RUN;
      default: state_next = (drop_cnt_next != '0) ? ST_DRAIN : ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_dropped_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched_reg <= '0;
      perf_dropped_reg <= '0;
    end else begin
      perf_fetched_reg <= perf_fetched_reg + 32'(push);
      perf_dropped_reg <= perf_dropped_reg + 32'(rsp_drop)
                          + (redirect_valid ? 32'(fifo_count) : 32'd0);
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_dropped = perf_dropped_reg;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that produces the instruction stream consumed by the decode/control stage. Owns the fetch PC, issues in-order word requests to instruction memory, buffers returned words with their PCs in a small FIFO, and hands them to decode through a valid/ready handshake. Taken branches and jumps resolved downstream arrive as a redirect that flushes buffered and in-flight instructions.

## Interface
- RESET_PC, 32'h0100_0000, fetch PC loaded on reset
- FIFO_DEPTH, 4, instruction buffer entries and max in-flight requests (power of 2, ≥2)
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response word valid (in order, ≥1 cycle after request)
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of inst
- redirect_valid  in  1  branch/jump taken (brn_tkn qualified)
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0)

## Operation
- Registers: fetch_pc (next request), rsp_pc (PC of next accepted response), outstanding (0..FIFO_DEPTH), drop_cnt (0..FIFO_DEPTH), FIFO of {pc, word}.
- FSM: IDLE → RUN one cycle after reset deasserts; RUN → DRAIN on redirect with stale requests in flight; DRAIN → RUN when drop_cnt reaches 0. Redirect in DRAIN reloads drop_cnt.
- Issue: imem_req_valid = state≠IDLE && !redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH. imem_req_addr = fetch_pc. Handshake → fetch_pc += 4 (32-bit wrap), outstanding += 1.
- Response: outstanding −= 1. If drop_cnt>0: discard, drop_cnt −= 1. Else push {rsp_pc, imem_rsp_data}, rsp_pc += 4. Space is guaranteed by the issue rule; no overflow possible.
- Decode side: inst_valid = FIFO non-empty && !redirect_valid; inst/inst_pc = FIFO head. Pop on inst_valid && inst_ready.
- Redirect: next edge flushes FIFO, fetch_pc ← rsp_pc ← {redirect_pc[31:2],2'b00}, drop_cnt ← outstanding after this cycle's response, i.e. every request accepted before the redirect cycle is discarded, including a response arriving in the redirect cycle. No request issued in the redirect cycle.
- Simultaneous push+pop with FIFO full-at-start is legal; count unchanged.

## Timing
- Reset values: imem_req_valid 0, imem_req_addr RESET_PC, inst_valid 0, inst 32'h0000_0013 (NOP), inst_pc RESET_PC, all counters 0, state IDLE.
- First request: cycle 1 after reset release, addr RESET_PC.
- Response in cycle N → inst_valid in N+1 (registered FIFO, no bypass).
- Redirect in cycle R → request to target in R+1, earliest inst_valid for target at R+3 with 1-cycle memory.
- Steady state: 1 instruction/cycle with 1-cycle memory and inst_ready high.
- Reset asserted mid-operation: immediate return to reset values; in-flight responses after release are not the block's concern (memory reset together).

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32, pushed instructions) and perf_dropped (32, discarded responses + flushed FIFO entries), reset 0, wrapping.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared package/header rv_pkg: RV_NOP (32'h0000_0013), default RESET_PC, FSM state encodings for IDLE/RUN/DRAIN.
- One sub-module fetch_fifo: synchronous FIFO of 64-bit {pc,word}, parameter DEPTH, ports push/pop/flush/count/empty/full.

## Test plan
- Reset release, 1-cycle memory, inst_ready=1 → requests 0x0100_0000, 0x0100_0004, …; first inst_valid cycle 3 with inst_pc 0x0100_0000, then one per cycle.
- inst_ready=0 for 10 cycles → exactly 4 requests issued, imem_req_valid low afterwards, no lost words when ready returns.
- 3-cycle memory latency, redirect to 0x0100_0200 with 3 in flight → those 3 responses dropped, next inst_pc 0x0100_0200.
- Redirect in same cycle as response and pop → response discarded, inst_valid low that cycle, FIFO empty next cycle.
- Back-to-back redirects (0x40 then 0x80) → only 0x80 stream delivered; redirect_pc 0x83 → fetch at 0x80.
- imem_req_ready toggling randomly → addresses strictly +4 per accepted request; with FETCH_PERF_EN perf counters match scoreboard.
